simple_gray2bin: RTL

Register-mapped Gray-to-binary decoder with an internal synchronous FIFO. It is the receive-side counterpart of the binary-to-Gray encoder block.

- Software or an upstream agent writes Gray-coded words into the FIFO through a simple enable/addr/write/read bus.
- Reads pop the head entry and return it decoded to binary.
- Status and control sit at a fixed register address.

---
 rtl/g2b_pkg.sv | 25 ++
 rtl/simple_gray2bin_if.sv | 31 +++
 rtl/g2b_sync_fifo.sv | 72 +++++++
 rtl/simple_gray2bin.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/g2b_pkg.sv
// ============================================================================
// Module   : g2b_pkg
// Brief    : Register map and status bit positions for simple_gray2bin.
// Revision : 1.0
// ============================================================================
`default_nettype none

package g2b_pkg;

    typedef enum logic [1:0] {
        ADDR_DATA  = 2'd0,
        ADDR_RAW   = 2'd1,
        ADDR_LEVEL = 2'd2,
        ADDR_CTL   = 2'd3
    } reg_addr_e;

    localparam int EMPTY   = 0;
    localparam int FULL    = 1;
    localparam int OVF     = 2;
    localparam int UDF     = 3;
    localparam int CLR_BIT = 0;

endpackage

`default_nettype wire

// File: rtl/simple_gray2bin_if.sv
// ============================================================================
// Module   : simple_gray2bin_if
// Brief    : Enable/addr/write/read register bus with access-complete response.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface simple_gray2bin_if #(
    parameter int DATA_W = 8
) ();
    logic              enable;
    logic [1:0]        addr;
    logic              write;
    logic              read;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ready;
    logic              resp;

    modport master (
        output enable, addr, write, read, wdata,
        input  rdata, ready, resp
    );

    modport slave (
        input  enable, addr, write, read, wdata,
        output rdata, ready, resp
    );
endinterface

`default_nettype wire

// File: rtl/g2b_sync_fifo.sv
// ============================================================================
// Module   : g2b_sync_fifo
// Brief    : Synchronous FIFO with extra-MSB pointers, clear and fill level.
// Revision : 1.0
// ============================================================================
`default_nettype none

module g2b_sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              push_i,
    input  wire logic              pop_i,
    input  wire logic              clr_i,
    input  wire logic [DATA_W-1:0] wdata_i,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [AW:0]            level_o,
    output logic [DATA_W-1:0]      head_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic              do_push;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign level_o = wr_ptr_q - rd_ptr_q;
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign do_push = push_i && !full_o && !clr_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
            end
            if (pop_i && !empty_o) begin
                rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/simple_gray2bin.sv
// ============================================================================
// Module   : simple_gray2bin
// Brief    : Register-mapped Gray-to-binary decoder in front of a sync FIFO.
// Revision : 1.0
// ============================================================================
`default_nettype none

module simple_gray2bin
    import g2b_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  wire logic         clk,
    input  wire logic         rst,
    simple_gray2bin_if.slave  bus
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic              push, pop, clr;
    logic              fifo_full, fifo_empty;
    logic [AW:0]       fifo_level;
    logic [DATA_W-1:0] fifo_head;

    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ready_q, ready_d;
    logic              resp_q,  resp_d;
    logic              ovf_q,   ovf_d;
    logic              udf_q,   udf_d;

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [DATA_W-1:0] gray2bin(input logic [DATA_W-1:0] g);
        logic [DATA_W-1:0] b;
        for (int i = 0; i < DATA_W; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

    g2b_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .clr_i   (clr),
        .wdata_i (bus.wdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level),
        .head_o  (fifo_head)
    );

    always_comb begin
        push    = 1'b0;
        pop     = 1'b0;
        clr     = 1'b0;
        ready_d = bus.enable && (bus.write || bus.read);
        resp_d  = 1'b0;
        rdata_d = '0;
        ovf_d   = ovf_q;
        udf_d   = udf_q;

        if (bus.enable && bus.write && bus.read) begin
            resp_d = 1'b1;
        end else if (bus.enable && bus.write) begin
            case (reg_addr_e'(bus.addr))
                ADDR_DATA: begin
                    if (fifo_full) begin
                        resp_d = 1'b1;
                        ovf_d  = 1'b1;
                    end else begin
                        push = 1'b1;
                    end
                end
                ADDR_RAW, ADDR_LEVEL: resp_d = 1'b1;
                ADDR_CTL: begin
                    if (bus.wdata[CLR_BIT]) begin
                        clr   = 1'b1;
                        ovf_d = 1'b0;
                        udf_d = 1'b0;
                    end
                end
                default: resp_d = 1'b1;
            endcase
        end else if (bus.enable && bus.read) begin
            case (reg_addr_e'(bus.addr))
                ADDR_DATA: begin
                    if (fifo_empty) begin
                        resp_d = 1'b1;
                        udf_d  = 1'b1;
                    end else begin
                        pop     = 1'b1;
                        rdata_d = gray2bin(fifo_head);
                    end
                end
                ADDR_RAW: begin
                    if (fifo_empty) begin
                        resp_d = 1'b1;
                    end else begin
                        rdata_d = fifo_head;
                    end
                end
                ADDR_LEVEL: rdata_d = DATA_W'(fifo_level);
                ADDR_CTL: begin
                    rdata_d[EMPTY] = fifo_empty;
                    rdata_d[FULL]  = fifo_full;
                    rdata_d[OVF]   = ovf_q;
                    rdata_d[UDF]   = udf_q;
                end
                default: resp_d = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
            ready_q <= 1'b0;
            resp_q  <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            resp_q  <= resp_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.ready = ready_q;
    assign bus.resp  = resp_q;

endmodule

`default_nettype wire
